// File: rtl/seg_capture.sv
// Seven-segment readback: decodes multiplexed active-low segment samples per digit,
// debounces them over STABLE identical samples, and keeps committed value/flags.
module seg_capture #(
    parameter int DIGITS = 6,
    parameter int STABLE = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            seg_in,
    input  logic                  sample,
    input  logic [2:0]            digit_sel,
    input  logic                  ack,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     valid,
    output logic [DIGITS-1:0]     err,
    output logic [DIGITS-1:0]     changed,
    output logic                  irq
);

    // Class code: {1, n} is HEX(n); the remaining codes are BLANK, BAD and NONE.
    localparam logic [4:0] CLS_BLANK = 5'b00000;
    localparam logic [4:0] CLS_BAD   = 5'b00001;
    localparam logic [4:0] CLS_NONE  = 5'b00010;
    localparam logic [3:0] STABLE_C  = 4'(STABLE);

    function automatic logic [4:0] decode(input logic [6:0] p);
        logic [4:0] c;
        case (p)
            7'b0000000: c = CLS_BLANK;
            7'b0111111: c = 5'h10;
            7'b0000110: c = 5'h11;
            7'b1011011: c = 5'h12;
            7'b1001111: c = 5'h13;
            7'b1100110: c = 5'h14;
            7'b1101101: c = 5'h15;
            7'b1111101: c = 5'h16;
            7'b0000111: c = 5'h17;
            7'b1111111: c = 5'h18;
            7'b1101111: c = 5'h19;
            7'b1110111: c = 5'h1A;
            7'b1111100: c = 5'h1B;
            7'b0111001: c = 5'h1C;
            7'b1011110: c = 5'h1D;
            7'b1111001: c = 5'h1E;
            7'b1110001: c = 5'h1F;
            default:    c = CLS_BAD;
        endcase
        return c;
    endfunction

    logic [DIGITS-1:0][4:0] cand_q, cand_d;
    logic [DIGITS-1:0][4:0] com_q, com_d;
    logic [DIGITS-1:0][3:0] cnt_q, cnt_d;
    logic [DIGITS-1:0][3:0] value_q, value_d;
    logic [DIGITS-1:0]      valid_q, valid_d;
    logic [DIGITS-1:0]      err_q, err_d;
    logic [DIGITS-1:0]      changed_q, changed_d;

    logic [4:0] cls;
    logic       hit;
    logic       fresh;

    assign cls = decode(~seg_in);
    assign hit = sample && ({1'b0, digit_sel} < 4'(DIGITS));

    always_comb begin
        cand_d    = cand_q;
        com_d     = com_q;
        cnt_d     = cnt_q;
        value_d   = value_q;
        valid_d   = valid_q;
        err_d     = err_q;
        changed_d = ack ? '0 : changed_q;
        fresh     = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (hit && digit_sel == 3'(d)) begin
                fresh    = (cls != cand_q[d]);
                cand_d[d] = cls;
                if (fresh)
                    cnt_d[d] = 4'd1;
                else if (cnt_q[d] != STABLE_C)
                    cnt_d[d] = cnt_q[d] + 4'd1;
                // A restart counts as freshly reaching STABLE, so STABLE=1 commits on any new class.
                if (cnt_d[d] == STABLE_C && (fresh || cnt_q[d] != STABLE_C) && cls != com_q[d]) begin
                    com_d[d]     = cls;
                    value_d[d]   = cls[4] ? cls[3:0] : 4'd0;
                    valid_d[d]   = cls[4];
                    err_d[d]     = (cls == CLS_BAD);
                    changed_d[d] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cand_q    <= {DIGITS{CLS_NONE}};
            com_q     <= {DIGITS{CLS_BLANK}};
            cnt_q     <= '0;
            value_q   <= '0;
            valid_q   <= '0;
            err_q     <= '0;
            changed_q <= '0;
        end else begin
            cand_q    <= cand_d;
            com_q     <= com_d;
            cnt_q     <= cnt_d;
            value_q   <= value_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            changed_q <= changed_d;
        end
    end

    assign value   = value_q;
    assign valid   = valid_q;
    assign err     = err_q;
    assign changed = changed_q;
    assign irq     = |changed_q;

endmodule

// File: tb/tb_seg_capture.sv
// Scoreboard bench for seg_capture: a run-length reference model pushes expected
// outputs per cycle; a monitor pops and compares after each rising edge.
module tb_seg_capture;
    localparam int DIGITS = 6;
    localparam int STABLE = 3;

    logic                clk = 1'b0;
    logic                reset;
    logic [6:0]          seg_in;
    logic                sample;
    logic [2:0]          digit_sel;
    logic                ack;
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   valid, err, changed;
    logic                irq;

    seg_capture #(.DIGITS(DIGITS), .STABLE(STABLE)) dut (
        .clk(clk), .reset(reset), .seg_in(seg_in), .sample(sample),
        .digit_sel(digit_sel), .ack(ack), .value(value), .valid(valid),
        .err(err), .changed(changed), .irq(irq)
    );

    always #5 clk = ~clk;

    logic [6:0] GLY [16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                             7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                             7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                             7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

    typedef struct {
        logic [4*DIGITS-1:0] value;
        logic [DIGITS-1:0]   valid, err, changed;
        logic                irq;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model: class 0..15 hex, 16 blank, 17 bad, -1 none; run is an unsaturated run length.
    int          m_last [DIGITS];
    int          m_run  [DIGITS];
    int          m_com  [DIGITS];
    logic [DIGITS-1:0] m_chg;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int classify(input logic [6:0] seg);
        logic [6:0] p;
        p = ~seg;
        if (p == 7'd0) return 16;
        for (int i = 0; i < 16; i++) if (GLY[i] == p) return i;
        return 17;
    endfunction

    function automatic logic [6:0] hexseg(input int n);
        return ~GLY[n];
    endfunction

    function automatic exp_t snapshot();
        exp_t e;
        e.value = '0; e.valid = '0; e.err = '0;
        for (int d = 0; d < DIGITS; d++) begin
            if (m_com[d] < 16) begin
                e.value[4*d +: 4] = 4'(m_com[d]);
                e.valid[d] = 1'b1;
            end
            e.err[d] = (m_com[d] == 17);
        end
        e.changed = m_chg;
        e.irq     = |m_chg;
        return e;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < DIGITS; d++) begin
            m_last[d] = -1; m_run[d] = 0; m_com[d] = 16;
        end
        m_chg = '0;
    endtask

    task automatic step(input logic r, input logic s, input logic [2:0] sel,
                        input logic [6:0] seg, input logic a);
        logic [DIGITS-1:0] nc;
        int c;
        @(negedge clk);
        reset = r; sample = s; digit_sel = sel; seg_in = seg; ack = a;
        if (r) model_reset();
        else begin
            nc = a ? '0 : m_chg;
            if (s && int'(sel) < DIGITS) begin
                c = classify(seg);
                if (c == m_last[sel]) m_run[sel]++;
                else begin m_last[sel] = c; m_run[sel] = 1; end
                if (m_run[sel] == STABLE && c != m_com[sel]) begin
                    m_com[sel] = c;
                    nc[sel] = 1'b1;
                end
            end
            m_chg = nc;
        end
        exp_q.push_back(snapshot());
    endtask

    task automatic samp(input int d, input logic [6:0] seg, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 3'(d), seg, 1'b0);
    endtask

    // Monitor: every rising edge presents one cycle's outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("value",   32'(value),   32'(e.value));
                chk("valid",   32'(valid),   32'(e.valid));
                chk("err",     32'(err),     32'(e.err));
                chk("changed", 32'(changed), 32'(e.changed));
                chk("irq",     32'(irq),     32'(e.irq));
            end
        end
    end

    initial begin
        logic [2:0] rsel;
        logic [6:0] rseg;
        reset = 1'b1; sample = 1'b0; digit_sel = '0; seg_in = 7'h7F; ack = 1'b0;
        model_reset();
        step(1'b1, 1'b0, 3'd0, 7'h7F, 1'b0);
        step(1'b0, 1'b0, 3'd0, 7'h7F, 1'b0);

        // Digit 2 commits to 3 only on the third sample.
        samp(2, hexseg(3), 2);
        @(posedge clk); #3;
        chk("t1_two_samples_no_commit", 32'(changed), 32'd0);
        samp(2, hexseg(3), 1);
        @(posedge clk); #3;
        chk("t1_value_digit2", 32'(value[11:8]), 32'd3);
        chk("t1_changed", 32'(changed), 32'h04);

        // Digit 0: commit A, then interrupted run before 5 commits.
        samp(0, hexseg(10), 3);
        samp(0, hexseg(10), 2);
        samp(0, hexseg(5), 2);
        samp(0, hexseg(10), 1);
        samp(0, hexseg(5), 3);

        // Digit 4: bad pattern, then blank after an ack.
        samp(4, ~7'b0000001, 3);
        step(1'b0, 1'b0, 3'd0, 7'h7F, 1'b1);
        samp(4, ~7'b0000000, 3);

        // changed = 100001, then a digit 1 commit coinciding with ack.
        step(1'b0, 1'b0, 3'd0, 7'h7F, 1'b1);
        samp(0, hexseg(1), 3);
        samp(5, hexseg(7), 3);
        samp(1, hexseg(2), 2);
        step(1'b0, 1'b1, 3'd1, hexseg(2), 1'b1);
        @(posedge clk); #3;
        chk("t4_ack_with_commit", 32'(changed), 32'h02);

        // Out-of-range digit and re-sampling a committed value change nothing.
        step(1'b0, 1'b0, 3'd0, 7'h7F, 1'b1);
        samp(7, hexseg(8), 5);
        samp(5, hexseg(7), 6);

        // Reset between second and third sample clears outputs immediately.
        samp(3, hexseg(9), 2);
        @(negedge clk);
        reset = 1'b1; sample = 1'b0;
        #1;
        chk("t6_async_value", 32'(value), 32'd0);
        chk("t6_async_valid", 32'(valid), 32'd0);
        chk("t6_async_irq", 32'(irq), 32'd0);
        model_reset();
        exp_q.push_back(snapshot());
        step(1'b0, 1'b0, 3'd0, 7'h7F, 1'b0);
        samp(3, hexseg(9), 2);
        @(posedge clk); #3;
        chk("t6_no_commit_after_reset", 32'(valid), 32'd0);
        samp(3, hexseg(9), 1);

        // Randomized runs with a small pattern pool so commits happen often.
        rsel = 3'd0; rseg = hexseg(3);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) < 3) begin
                rsel = 3'($urandom_range(0, 7));
                case ($urandom_range(0, 5))
                    0: rseg = hexseg(3);
                    1: rseg = hexseg(10);
                    2: rseg = 7'h7F;
                    3: rseg = ~7'b0000001;
                    4: rseg = hexseg(int'($urandom_range(0, 15)));
                    default: rseg = 7'($urandom);
                endcase
            end
            step(($urandom_range(0, 499) == 0), ($urandom_range(0, 99) < 85),
                 rsel, rseg, ($urandom_range(0, 9) == 0));
        end

        repeat (3) @(posedge clk);
        #5;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
